// File: rtl/ahb_split_slave_ctrl_if.sv
// Bus-side signal bundle for the AHB split-capable slave response controller.
// The slave modport is the controller's view; the master modport is the bus/bench view.
interface ahb_split_slave_ctrl_if;
    logic        HSEL;
    logic [1:0]  HTRANS;
    logic        HREADY;
    logic [3:0]  HMASTER;
    logic        HMASTLOCK;
    logic        be_ready;
    logic        HREADYOUT;
    logic [1:0]  HRESP;
    logic [15:0] HSPLIT;
    logic        xfer_accept;
    logic [15:0] split_pending;

    modport slave (
        input  HSEL, HTRANS, HREADY, HMASTER, HMASTLOCK, be_ready,
        output HREADYOUT, HRESP, HSPLIT, xfer_accept, split_pending
    );

    modport master (
        output HSEL, HTRANS, HREADY, HMASTER, HMASTLOCK, be_ready,
        input  HREADYOUT, HRESP, HSPLIT, xfer_accept, split_pending
    );
endinterface

// File: rtl/ahb_split_slave_ctrl.sv
// AHB slave response controller: zero-wait OKAY, two-cycle SPLIT, bounded locked waits ending in
// ERROR, and registered one-hot HSPLIT release of split masters, lowest index first.
module ahb_split_slave_ctrl #(
    parameter int unsigned NUM_MASTERS   = 16,
    parameter int unsigned LOCK_WAIT_MAX = 15
) (
    input logic                     HCLK,
    input logic                     HRESET,
    ahb_split_slave_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        StIdle,
        StSplit1,
        StSplit2,
        StLwait,
        StErr1,
        StErr2
    } state_e;

    localparam logic [16:0] MaskWide   = (17'd1 << NUM_MASTERS) - 17'd1;
    localparam logic [15:0] MasterMask = MaskWide[15:0];
    localparam logic [7:0]  WaitLast   = 8'(LOCK_WAIT_MAX - 1);

    state_e      r_state;
    state_e      w_state_d;
    logic [7:0]  r_wait_cnt;
    logic [7:0]  w_wait_cnt_d;
    logic [15:0] r_pending;
    logic [15:0] w_pending_d;
    logic [15:0] r_hsplit;
    logic [15:0] w_hsplit_d;
    logic        r_hreadyout;
    logic        w_hreadyout_d;
    logic [1:0]  r_hresp;
    logic [1:0]  w_hresp_d;
    logic        r_xfer;
    logic        w_xfer_d;

    logic        w_valid_ap;
    logic [15:0] w_set;
    logic [15:0] w_clr;
    logic [15:0] w_lowest;

    assign w_valid_ap = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
    // x & -x isolates the lowest set bit
    assign w_lowest   = r_pending & (~r_pending + 16'd1);

    always_comb begin
        w_state_d    = r_state;
        w_wait_cnt_d = r_wait_cnt;
        w_set        = '0;
        w_clr        = '0;
        w_xfer_d     = 1'b0;
        w_hsplit_d   = '0;
        unique case (r_state)
            StIdle: begin
                if (w_valid_ap) begin
                    if (bus.be_ready) begin
                        w_xfer_d = 1'b1;
                    end else if (!bus.HMASTLOCK) begin
                        w_state_d = StSplit1;
                        if (32'(bus.HMASTER) < NUM_MASTERS) begin
                            w_set[bus.HMASTER] = 1'b1;
                        end
                    end else begin
                        w_state_d    = StLwait;
                        w_wait_cnt_d = '0;
                    end
                end else if (bus.be_ready && (r_pending != '0)) begin
                    w_clr      = w_lowest;
                    w_hsplit_d = w_lowest;
                end
            end
            StSplit1: w_state_d = StSplit2;
            StSplit2: w_state_d = StIdle;
            StLwait: begin
                if (bus.be_ready) begin
                    w_state_d = StIdle;
                    w_xfer_d  = 1'b1;
                end else if (r_wait_cnt == WaitLast) begin
                    w_state_d = StErr1;
                end else begin
                    w_wait_cnt_d = r_wait_cnt + 8'd1;
                end
            end
            StErr1:  w_state_d = StErr2;
            StErr2:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase

        // Set is applied after clear so a same-cycle set always wins
        w_pending_d = ((r_pending & ~w_clr) | w_set) & MasterMask;

        w_hreadyout_d = 1'b1;
        w_hresp_d     = 2'b00;
        unique case (w_state_d)
            StIdle:   begin w_hreadyout_d = 1'b1; w_hresp_d = 2'b00; end
            StSplit1: begin w_hreadyout_d = 1'b0; w_hresp_d = 2'b11; end
            StSplit2: begin w_hreadyout_d = 1'b1; w_hresp_d = 2'b11; end
            StLwait:  begin w_hreadyout_d = 1'b0; w_hresp_d = 2'b00; end
            StErr1:   begin w_hreadyout_d = 1'b0; w_hresp_d = 2'b01; end
            StErr2:   begin w_hreadyout_d = 1'b1; w_hresp_d = 2'b01; end
            default:  begin w_hreadyout_d = 1'b1; w_hresp_d = 2'b00; end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state     <= StIdle;
            r_wait_cnt  <= '0;
            r_pending   <= '0;
            r_hsplit    <= '0;
            r_hreadyout <= 1'b1;
            r_hresp     <= 2'b00;
            r_xfer      <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_wait_cnt  <= w_wait_cnt_d;
            r_pending   <= w_pending_d;
            r_hsplit    <= w_hsplit_d & MasterMask;
            r_hreadyout <= w_hreadyout_d;
            r_hresp     <= w_hresp_d;
            r_xfer      <= w_xfer_d;
        end
    end

    assign bus.HREADYOUT     = r_hreadyout;
    assign bus.HRESP         = r_hresp;
    assign bus.HSPLIT        = r_hsplit;
    assign bus.xfer_accept   = r_xfer;
    assign bus.split_pending = r_pending;

endmodule

// File: tb/tb_ahb_split_slave_ctrl.sv
// Directed bench for ahb_split_slave_ctrl: a transaction-level response model checked every cycle,
// plus hand-computed literal checks for each scenario.
module tb_ahb_split_slave_ctrl;

    localparam int unsigned NumMasters  = 16;
    localparam int unsigned LockWaitMax = 15;

    logic HCLK = 1'b0;
    logic HRESET = 1'b1;
    always #5 HCLK = ~HCLK;

    ahb_split_slave_ctrl_if bus_if ();

    ahb_split_slave_ctrl #(
        .NUM_MASTERS  (NumMasters),
        .LOCK_WAIT_MAX(LockWaitMax)
    ) dut (
        .HCLK  (HCLK),
        .HRESET(HRESET),
        .bus   (bus_if)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Response model: upcoming {HREADYOUT,HRESP} values queued per cycle, pending kept as a bit set
    logic [2:0]  m_q[$];
    logic        m_rdy, m_xfer;
    logic [1:0]  m_resp;
    logic [15:0] m_split, m_pend;
    bit          m_on = 0, m_idle = 1, m_lwait = 0;
    int          m_waits_done = 0;

    always @(posedge HCLK) begin
        bit vap;
        logic [2:0] r;
        vap = bus_if.HSEL & bus_if.HTRANS[1] & bus_if.HREADY;
        if (HRESET) begin
            m_on = 1; m_rdy = 1; m_resp = 0; m_split = 0; m_xfer = 0; m_pend = 0;
            m_q.delete(); m_idle = 1; m_lwait = 0; m_waits_done = 0;
        end else begin
            m_xfer  = 0;
            m_split = 0;
            if (m_lwait) begin
                if (bus_if.be_ready) begin
                    m_lwait = 0; m_idle = 1; m_xfer = 1; m_rdy = 1; m_resp = 2'b00;
                end else if (m_waits_done == LockWaitMax) begin
                    m_lwait = 0; m_rdy = 0; m_resp = 2'b01;
                    m_q.push_back(3'b101);
                end else begin
                    m_waits_done++; m_rdy = 0; m_resp = 2'b00;
                end
            end else if (!m_idle) begin
                if (m_q.size() > 0) begin
                    r = m_q.pop_front();
                    m_rdy = r[2]; m_resp = r[1:0];
                end else begin
                    m_idle = 1; m_rdy = 1; m_resp = 2'b00;
                end
            end else if (vap) begin
                if (bus_if.be_ready) begin
                    m_xfer = 1; m_rdy = 1; m_resp = 2'b00;
                end else if (!bus_if.HMASTLOCK) begin
                    m_idle = 0; m_rdy = 0; m_resp = 2'b11;
                    m_q.push_back(3'b111);
                    if (int'(bus_if.HMASTER) < NumMasters) m_pend[bus_if.HMASTER] = 1'b1;
                end else begin
                    m_idle = 0; m_lwait = 1; m_waits_done = 1; m_rdy = 0; m_resp = 2'b00;
                end
            end else begin
                m_rdy = 1; m_resp = 2'b00;
                if (bus_if.be_ready && m_pend != 0) begin
                    for (int i = 0; i < 16; i++) begin
                        if (m_pend[i]) begin
                            m_split[i] = 1'b1;
                            m_pend[i]  = 1'b0;
                            break;
                        end
                    end
                end
            end
        end
    end

    always @(negedge HCLK) begin
        if (m_on) begin
            cmp("mdl_hreadyout", 32'(bus_if.HREADYOUT), 32'(m_rdy));
            cmp("mdl_hresp", 32'(bus_if.HRESP), 32'(m_resp));
            cmp("mdl_hsplit", 32'(bus_if.HSPLIT), 32'(m_split));
            cmp("mdl_xfer_accept", 32'(bus_if.xfer_accept), 32'(m_xfer));
            cmp("mdl_split_pending", 32'(bus_if.split_pending), 32'(m_pend));
        end
    end

    task automatic step();
        @(negedge HCLK);
    endtask

    task automatic ap(input logic [3:0] mst, input logic lock, input logic be);
        bus_if.HSEL = 1'b1; bus_if.HTRANS = 2'b10; bus_if.HREADY = 1'b1;
        bus_if.HMASTER = mst; bus_if.HMASTLOCK = lock; bus_if.be_ready = be;
    endtask

    task automatic idle(input logic be);
        bus_if.HSEL = 1'b0; bus_if.HTRANS = 2'b00; bus_if.HREADY = 1'b1;
        bus_if.HMASTER = 4'd0; bus_if.HMASTLOCK = 1'b0; bus_if.be_ready = be;
    endtask

    function automatic logic [31:0] rr();
        return 32'({bus_if.HREADYOUT, bus_if.HRESP});
    endfunction

    task automatic chk_reset(input string tag);
        cmp({tag, "_hreadyout"}, 32'(bus_if.HREADYOUT), 32'd1);
        cmp({tag, "_hresp"}, 32'(bus_if.HRESP), 32'd0);
        cmp({tag, "_hsplit"}, 32'(bus_if.HSPLIT), 32'd0);
        cmp({tag, "_xfer"}, 32'(bus_if.xfer_accept), 32'd0);
        cmp({tag, "_pending"}, 32'(bus_if.split_pending), 32'd0);
    endtask

    initial begin
        idle(1'b0);
        HRESET = 1'b1;
        repeat (2) step();
        chk_reset("rst");
        HRESET = 1'b0;

        // Zero-wait accept
        ap(4'd0, 1'b0, 1'b1); step();
        cmp("t1_xfer", 32'(bus_if.xfer_accept), 32'd1);
        cmp("t1_rr", rr(), 32'h4);
        idle(1'b0); step();
        cmp("t1_xfer_end", 32'(bus_if.xfer_accept), 32'd0);

        // Split master 3, then release
        ap(4'd3, 1'b0, 1'b0); step();
        cmp("t2_split1", rr(), 32'h3);
        idle(1'b0); step();
        cmp("t2_split2", rr(), 32'h7);
        cmp("t2_pend", 32'(bus_if.split_pending), 32'h0008);
        step();
        cmp("t2_idle", rr(), 32'h4);
        idle(1'b1); step();
        cmp("t2_hsplit", 32'(bus_if.HSPLIT), 32'h0008);
        cmp("t2_pend_clr", 32'(bus_if.split_pending), 32'h0);
        step();
        cmp("t2_hsplit_end", 32'(bus_if.HSPLIT), 32'h0);

        // Masters 5 then 2; release lowest first
        ap(4'd5, 1'b0, 1'b0); step(); idle(1'b0); step(); step();
        ap(4'd2, 1'b0, 1'b0); step(); idle(1'b0); step(); step();
        cmp("t3_pend", 32'(bus_if.split_pending), 32'h0024);
        idle(1'b1); step();
        cmp("t3_hsplit_a", 32'(bus_if.HSPLIT), 32'h0004);
        step();
        cmp("t3_hsplit_b", 32'(bus_if.HSPLIT), 32'h0020);
        cmp("t3_pend_clr", 32'(bus_if.split_pending), 32'h0);
        step();
        cmp("t3_hsplit_end", 32'(bus_if.HSPLIT), 32'h0);

        // Locked timeout with master 7 pending
        ap(4'd7, 1'b0, 1'b0); step(); idle(1'b0); step(); step();
        ap(4'd1, 1'b1, 1'b0); step();
        cmp("t4_wait", rr(), 32'h0);
        idle(1'b0);
        for (int i = 1; i < 15; i++) begin
            step();
            cmp("t4_wait", rr(), 32'h0);
        end
        step();
        cmp("t4_err1", rr(), 32'h1);
        step();
        cmp("t4_err2", rr(), 32'h5);
        step();
        cmp("t4_idle", rr(), 32'h4);
        cmp("t4_pend", 32'(bus_if.split_pending), 32'h0080);
        idle(1'b1); step();
        cmp("t4_hsplit", 32'(bus_if.HSPLIT), 32'h0080);
        idle(1'b0); step();

        // Locked, back-end ready after 4 waits
        ap(4'd1, 1'b1, 1'b0); step();
        cmp("t5_wait1", rr(), 32'h0);
        idle(1'b0);
        for (int i = 2; i <= 4; i++) begin
            step();
            cmp("t5_wait", rr(), 32'h0);
        end
        idle(1'b1); step();
        cmp("t5_done", rr(), 32'h4);
        cmp("t5_xfer", 32'(bus_if.xfer_accept), 32'd1);
        idle(1'b0); step();
        cmp("t5_xfer_end", 32'(bus_if.xfer_accept), 32'd0);

        // Reset during SPLIT1 drops pending and suppresses release
        ap(4'd0, 1'b0, 1'b0); step(); idle(1'b0); step(); step();
        ap(4'd7, 1'b0, 1'b0); step(); idle(1'b0); step(); step();
        cmp("t6_pend", 32'(bus_if.split_pending), 32'h0081);
        ap(4'd7, 1'b0, 1'b0); step();
        cmp("t6_split1", rr(), 32'h3);
        HRESET = 1'b1; idle(1'b1); step();
        chk_reset("t6_rst");
        HRESET = 1'b0;
        repeat (4) begin
            step();
            cmp("t6_no_hsplit", 32'(bus_if.HSPLIT), 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
